i2s_dac_serializer: RTL and testbench
=====================================

// Module: i2s_dac_serializer
// PURPOSE
// - Transmit end of the audio path: takes filtered stereo 16-bit samples (FIR output side) and serializes
//   them to the DE2 WM8731 DAC as I2S master (BCLK, DACLRCK, DACDAT), mirroring the ADC deserializer.
// - Single-entry holding buffer with valid/ready handshake decouples the filter from the frame timing.
// - Both channels are latched as one pair, so a frame never mixes L/R from different samples.
// PARAMETERS
// - DATA_W     16  sample width, two's complement, MSB first
// - SLOT_W     32  BCLK periods per channel slot; must be >= DATA_W+1
// - BCLK_HALF  8   CLOCK_50 cycles per BCLK half-period (BCLK = 3.125 MHz, fs = 48.83 kHz)
// PORTS
// - CLOCK_50      in   1       system clock; the only clock
// - RESET         in   1       asynchronous, active-high reset
// - ENABLE        in   1       1 = run frames; 0 = stop at next frame boundary
// - SAMPLE_L      in   DATA_W  left sample
// - SAMPLE_R      in   DATA_W  right sample
// - SAMPLE_VALID  in   1       SAMPLE_L/R valid
// - SAMPLE_READY  out  1       holding buffer empty; transfer when VALID & READY at a CLOCK_50 edge
// - AUD_BCLK      out  1       bit clock to codec
// - AUD_DACLRCK   out  1       0 = left slot, 1 = right slot
// - AUD_DACDAT    out  1       serial data; changes on BCLK fall, codec samples on rise
// - UNDERRUN      out  1       one-cycle pulse: frame started with the buffer empty
// BEHAVIOUR
// - Reset: AUD_BCLK=0, AUD_DACLRCK=0, AUD_DACDAT=0, SAMPLE_READY=0, UNDERRUN=0, state=IDLE,
//   hold/shift regs=0, div_cnt=0, bit_cnt=0. All outputs are registered. SAMPLE_READY=1 one cycle after RESET falls.
// - Handshake: on VALID&READY latch L/R into hold, set hold_full, so READY=0 next cycle. VALID without READY is ignored.
//   Data changes while VALID=1 & READY=0 are allowed and not captured.
// - States: IDLE (BCLK/LRCK/DAT held 0, counters 0) -> RUN when ENABLE=1. RUN -> IDLE only at a frame boundary
//   with ENABLE=0; a started frame always completes all 2*SLOT_W bits.
// - Timing: div_cnt counts 0..BCLK_HALF-1; on the terminal count AUD_BCLK toggles. On each BCLK fall,
//   bit_cnt increments modulo 2*SLOT_W. AUD_DACLRCK = (bit_cnt >= SLOT_W).
// - Data: p = bit_cnt mod SLOT_W. For p in 1..DATA_W, DACDAT = word[DATA_W-p] (MSB one BCLK after LRCK edge, I2S).
//   For p = 0 and p > DATA_W, DACDAT = 0.
// - Frame boundary is the BCLK fall where bit_cnt wraps to 0, plus the IDLE->RUN entry.
//   - If hold_full: shift_l/r <= hold, hold_full <= 0, so READY=1 next cycle.
//   - Else: shift_l/r keep the previous pair (repeat last frame) and UNDERRUN pulses for one CLOCK_50 cycle.
// - Simultaneous events: a boundary transfer and VALID in the same cycle cannot both hit the hold register,
//   because READY=0 then. The new sample is accepted on the next READY cycle.
// - Latency: a sample accepted before a boundary has its L MSB on DACDAT one BCLK period after that boundary.
// - RESET asserted mid-frame aborts immediately to reset values. Buffered samples are discarded.
// - ENABLE=0 in IDLE: buffer still accepts one pair and holds it.
// STRUCTURE
// - Package i2s_pkg holds DATA_W/SLOT_W defaults, the state encoding (IDLE, RUN) and the frame-length constant 2*SLOT_W.
// - Sub-module i2s_clk_gen: div_cnt, BCLK, bit_cnt, LRCK, and bclk_fall/frame_start strobes.
//   The top holds the buffer, shifters and FSM.
// TESTING
// - Reset then ENABLE=1, push L=16'hA5F0 R=16'h0F0F -> 2nd frame DACDAT: L slot 0,A5F0 MSB-first,15x0; R slot 0,0F0F,15x0.
// - Check clocks at defaults -> BCLK period 16 CLOCK_50 cycles; LRCK period 64 BCLK; LRCK edges coincide with BCLK falls.
// - No push after first pair -> every later frame repeats that pair; UNDERRUN exactly 1 cycle per frame start.
// - Hold VALID=1 continuously with incrementing data -> one pair accepted per frame, none skipped or duplicated, READY low between.
// - ENABLE=0 at bit 10 of left slot -> frame finishes all 64 bits, then BCLK/LRCK/DAT stay 0.
// - RESET pulse mid-right-slot -> all outputs at reset values that same cycle; restart sends 0 until a new pair is accepted.

Source files
------------

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared defaults, frame length and FSM encoding
// for the I2S DAC transmit path.
package i2s_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int SLOT_W_DEF    = 32;
  localparam int BCLK_HALF_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int frame_len(input int slot_w);
    return 2 * slot_w;
  endfunction

  localparam int FRAME_LEN = frame_len(SLOT_W_DEF);

endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: BCLK divider, frame bit counter and LRCK.
// All state idles at 0 while run is low.
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter  int SLOT_W    = SLOT_W_DEF,
  parameter  int BCLK_HALF = BCLK_HALF_DEF,
  localparam int FRAME     = frame_len(SLOT_W),
  localparam int CNT_W     = $clog2(FRAME),
  localparam int DIV_W     = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             bclk,
  output logic             lrck,
  output logic [CNT_W-1:0] bit_next,
  output logic             bclk_fall,
  output logic             frame_start
);

  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic             div_tc;
  logic             bit_last;

  assign div_tc      = (div_cnt == DIV_W'(BCLK_HALF - 1));
  assign bit_last    = (bit_cnt == CNT_W'(FRAME - 1));
  assign bclk_fall   = run & div_tc & bclk;
  assign frame_start = bclk_fall & bit_last;
  assign bit_next    = bit_last ? '0 : bit_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= '0;
      lrck    <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= '0;
      lrck    <= 1'b0;
    end else begin
      div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
      if (div_tc)
        bclk <= ~bclk;
      // LRCK moves on the same BCLK fall as the counter
      if (bclk_fall) begin
        bit_cnt <= bit_next;
        lrck    <= (bit_next >= CNT_W'(SLOT_W));
      end
    end
  end

endmodule

// File: rtl/i2s_dac_serializer.sv
// i2s_dac_serializer: I2S master transmitter for the WM8731 DAC
// with a one-pair holding buffer and valid/ready intake.
module i2s_dac_serializer
  import i2s_pkg::*;
#(
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int SLOT_W    = SLOT_W_DEF,
  parameter  int BCLK_HALF = BCLK_HALF_DEF,
  localparam int CNT_W     = $clog2(frame_len(SLOT_W))
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic [DATA_W-1:0] SAMPLE_L,
  input  logic [DATA_W-1:0] SAMPLE_R,
  input  logic              SAMPLE_VALID,
  output logic              SAMPLE_READY,
  output logic              AUD_BCLK,
  output logic              AUD_DACLRCK,
  output logic              AUD_DACDAT,
  output logic              UNDERRUN
);

  state_t            state;
  logic [DATA_W-1:0] hold_l;
  logic [DATA_W-1:0] hold_r;
  logic [DATA_W-1:0] shift_l;
  logic [DATA_W-1:0] shift_r;
  logic              hold_full;
  logic              hold_full_n;
  logic              run;
  logic              accept;
  logic              start;
  logic              load;
  logic              bclk_fall;
  logic              frame_start;
  logic [CNT_W-1:0]  bit_next;
  logic [CNT_W-1:0]  pos;
  logic              slot_r;
  logic              in_data;

  assign run = (state == RUN);

  i2s_clk_gen #(
    .SLOT_W    (SLOT_W),
    .BCLK_HALF (BCLK_HALF)
  ) u_clk (
    .clk         (CLOCK_50),
    .rst         (RESET),
    .run         (run),
    .bclk        (AUD_BCLK),
    .lrck        (AUD_DACLRCK),
    .bit_next    (bit_next),
    .bclk_fall   (bclk_fall),
    .frame_start (frame_start)
  );

  assign accept      = SAMPLE_VALID & SAMPLE_READY;
  assign start       = ENABLE & (~run | frame_start);
  assign load        = start & hold_full;
  assign hold_full_n = accept | (hold_full & ~load);

  assign slot_r  = (bit_next >= CNT_W'(SLOT_W));
  assign pos     = slot_r ? bit_next - CNT_W'(SLOT_W) : bit_next;
  assign in_data = (pos != '0) && (pos <= CNT_W'(DATA_W));

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      hold_l       <= '0;
      hold_r       <= '0;
      shift_l      <= '0;
      shift_r      <= '0;
      hold_full    <= 1'b0;
      SAMPLE_READY <= 1'b0;
      UNDERRUN     <= 1'b0;
      AUD_DACDAT   <= 1'b0;
    end else begin
      hold_full    <= hold_full_n;
      SAMPLE_READY <= ~hold_full_n;
      UNDERRUN     <= start & ~hold_full;
      if (accept) begin
        hold_l <= SAMPLE_L;
        hold_r <= SAMPLE_R;
      end
      unique case (state)
        IDLE: begin
          AUD_DACDAT <= 1'b0;
          if (ENABLE)
            state <= RUN;
        end
        RUN: begin
          // rotate, not shift, so an underrun can replay the pair
          if (bclk_fall) begin
            AUD_DACDAT <= 1'b0;
            if (in_data && !slot_r) begin
              AUD_DACDAT <= shift_l[DATA_W-1];
              shift_l    <= {shift_l[DATA_W-2:0], shift_l[DATA_W-1]};
            end
            if (in_data && slot_r) begin
              AUD_DACDAT <= shift_r[DATA_W-1];
              shift_r    <= {shift_r[DATA_W-2:0], shift_r[DATA_W-1]};
            end
          end
          if (frame_start && !ENABLE)
            state <= IDLE;
        end
      endcase
      if (load) begin
        shift_l <= hold_l;
        shift_r <= hold_r;
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// tb_i2s_dac_serializer: vector table for the intake handshake,
// then frame-level scoreboard sequences on the serial output.
module tb_i2s_dac_serializer;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic        pad_bad;
  } frm_t;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [15:0] l;
    logic [15:0] r;
    logic [4:0]  exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] sl = '0;
  logic [15:0] sr = '0;
  logic        ready;
  logic        bclk;
  logic        lrck;
  logic        dat;
  logic        ur;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  frm_t cap_q[$];
  frm_t exp_q[$];

  int   m_p = 0;
  logic m_last = 1'b1;
  logic m_pb = 1'b0;
  logic m_pl = 1'b0;
  logic m_pd = 1'b0;
  logic m_pu = 1'b0;
  frm_t m_f;
  int   ur_cnt = 0;
  int   ur_wide = 0;
  int   lrck_edges = 0;
  int   lrck_bad = 0;
  int   dat_bad = 0;

  i2s_dac_serializer dut (
    .CLOCK_50     (clk),
    .RESET        (rst),
    .ENABLE       (en),
    .SAMPLE_L     (sl),
    .SAMPLE_R     (sr),
    .SAMPLE_VALID (valid),
    .SAMPLE_READY (ready),
    .AUD_BCLK     (bclk),
    .AUD_DACLRCK  (lrck),
    .AUD_DACDAT   (dat),
    .UNDERRUN     (ur)
  );

  always #10 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Frame monitor: samples DACDAT on BCLK rises, framed by LRCK
  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_p = 0;
      m_last = 1'b1;
      ur_cnt = 0;
      ur_wide = 0;
    end else begin
      if (bclk && !m_pb) begin
        if (lrck != m_last) m_p = 0;
        else m_p++;
        m_last = lrck;
        if (!lrck && m_p == 0) m_f = '0;
        if (m_p >= 1 && m_p <= 16) begin
          if (lrck) m_f.r[16-m_p] = dat;
          else m_f.l[16-m_p] = dat;
        end else if (dat) begin
          m_f.pad_bad = 1'b1;
        end
        if (lrck && m_p == 31) cap_q.push_back(m_f);
      end
      if (lrck != m_pl) begin
        lrck_edges++;
        if (!(m_pb && !bclk)) lrck_bad++;
      end
      if (dat != m_pd && !(m_pb && !bclk)) dat_bad++;
      if (ur) begin
        if (m_pu) ur_wide++;
        else ur_cnt++;
      end
    end
    m_pb = bclk;
    m_pl = lrck;
    m_pd = dat;
    m_pu = ur;
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic expect_frames(input int n, input string tag);
    frm_t g;
    frm_t e;
    bit   got;
    for (int k = 0; k < n; k++) begin
      got = 0;
      for (int i = 0; i < 3000; i++) begin
        if (cap_q.size() > 0) begin
          got = 1;
          break;
        end
        @(negedge clk);
      end
      total++;
      if (!got) begin
        bad++;
        $display("FAIL %s frame%0d timeout waiting for frame", tag, k);
      end else begin
        g = cap_q.pop_front();
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL %s frame%0d got L=%h R=%h want none",
                   tag, k, g.l, g.r);
        end else begin
          e = exp_q.pop_front();
          if (g.l !== e.l || g.r !== e.r || g.pad_bad) begin
            bad++;
            $display("FAIL %s frame%0d got L=%h R=%h pad_bad=%0d want L=%h R=%h",
                     tag, k, g.l, g.r, g.pad_bad, e.l, e.r);
          end
        end
      end
    end
  endtask

  task automatic wait_rise(input bit sel_lrck, output int t);
    logic pv;
    logic cv;
    t = -100000;
    pv = sel_lrck ? lrck : bclk;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      cv = sel_lrck ? lrck : bclk;
      if (cv && !pv) begin
        t = cyc;
        return;
      end
      pv = cv;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    valid = 1'b0;
    repeat (3) @(posedge clk);
    cap_q.delete();
    exp_q.delete();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  vec_t vt[9];
  int   t0, t1, n_acc, quiet;
  bit   stop;
  logic [15:0] d;

  initial begin
    vt[0] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 5'b00000};
    vt[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 5'b10000};
    vt[2] = '{1'b0, 1'b1, 16'h1111, 16'h2222, 5'b00000};
    vt[3] = '{1'b0, 1'b1, 16'h3333, 16'h4444, 5'b00000};
    vt[4] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 5'b00000};
    vt[5] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 5'b00000};
    vt[6] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 5'b10000};
    vt[7] = '{1'b0, 1'b1, 16'h3C3C, 16'hC3C3, 5'b00000};
    vt[8] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 5'b00000};

    @(posedge clk);
    #1;
    foreach (vt[i]) begin
      rst = vt[i].rst;
      valid = vt[i].valid;
      sl = vt[i].l;
      sr = vt[i].r;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), {27'd0, ready, ur, bclk, lrck, dat},
          {27'd0, vt[i].exp});
    end

    // pair held while idle goes out first; stop at left bit 10
    exp_q.push_back('{16'h3C3C, 16'hC3C3, 1'b0});
    en = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (m_p == 10 && m_last == 1'b0) break;
    end
    #1 en = 1'b0;
    expect_frames(1, "stop");
    repeat (12) @(negedge clk);
    quiet = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bclk || lrck || dat) quiet++;
    end
    chk("idle_quiet", quiet, 0);
    chk("idle_no_frame", cap_q.size(), 0);
    chk("stop_underrun", ur_cnt, 0);

    // push together with enable: first frame silent, then repeats
    do_reset();
    en = 1'b1;
    valid = 1'b1;
    sl = 16'hA5F0;
    sr = 16'h0F0F;
    exp_q.push_back('{16'h0000, 16'h0000, 1'b0});
    repeat (3) exp_q.push_back('{16'hA5F0, 16'h0F0F, 1'b0});
    @(posedge clk);
    #1 valid = 1'b0;
    expect_frames(4, "basic");
    chk("basic_underrun", ur_cnt, 3);
    chk("basic_ur_width", ur_wide, 0);
    wait_rise(1'b0, t0);
    wait_rise(1'b0, t1);
    chk("bclk_period", t1 - t0, 16);
    wait_rise(1'b1, t0);
    wait_rise(1'b1, t1);
    chk("lrck_period", t1 - t0, 1024);

    // VALID held with fresh data each accept
    do_reset();
    d = 16'h0100;
    sl = d;
    sr = ~d;
    exp_q.push_back('{16'h0000, 16'h0000, 1'b0});
    en = 1'b1;
    valid = 1'b1;
    stop = 0;
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 20000 && !stop; i++) begin
          @(negedge clk);
          if (!stop && ready && valid) begin
            exp_q.push_back('{sl, sr, 1'b0});
            n_acc++;
            @(posedge clk);
            #1;
            d = d + 16'h0001;
            sl = d;
            sr = ~d;
          end
        end
      end
      begin
        expect_frames(5, "stream");
        chk("stream_accepts", n_acc, 5);
        chk("stream_underrun", ur_cnt, 1);
        stop = 1;
      end
    join
    valid = 1'b0;

    // reset mid right slot, then restart from silence
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (m_p == 8 && m_last == 1'b1) break;
    end
    #2 rst = 1'b1;
    #1;
    chk("async_reset", {27'd0, ready, ur, bclk, lrck, dat}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    cap_q.delete();
    exp_q.delete();
    exp_q.push_back('{16'h0000, 16'h0000, 1'b0});
    exp_q.push_back('{16'h0BAD, 16'hF00D, 1'b0});
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sl = 16'h0BAD;
    sr = 16'hF00D;
    valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready) break;
    end
    @(posedge clk);
    #1 valid = 1'b0;
    expect_frames(2, "restart");
    chk("restart_underrun", ur_cnt, 1);

    chk("lrck_align", lrck_bad, 0);
    chk("lrck_seen", (lrck_edges > 0) ? 1 : 0, 1);
    chk("dat_on_fall", dat_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
